// File: rtl/keypad_bcd_entry_pkg.sv
// rtl/keypad_bcd_entry_pkg.sv - keypad FSM states, key map table and row decode helpers
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    PRESSED  = 2'd2,
    RELEASE  = 2'd3
  } state_e;

  localparam logic [3:0] KEY_CLEAR = 4'hA;
  localparam logic [3:0] ROW_IDLE  = 4'hF;

  // Indexed by {row index, column index}.
  localparam logic [3:0] KEY_MAP [16] = '{
    4'h1, 4'h2, 4'h3, 4'hA,
    4'h4, 4'h5, 4'h6, 4'hB,
    4'h7, 4'h8, 4'h9, 4'hC,
    4'hE, 4'h0, 4'hF, 4'hD
  };

  function automatic logic is_single_key(input logic [3:0] row);
    return ($countones(~row) == 1);
  endfunction

  function automatic logic [1:0] row_index(input logic [3:0] row);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (!row[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/keypad_bcd_entry_if.sv
// rtl/keypad_bcd_entry_if.sv - keypad matrix and BCD entry signal bundle
interface keypad_bcd_entry_if;
  logic [3:0] row_in;
  logic [3:0] col_out;
  logic [3:0] key_code;
  logic       key_valid;
  logic [3:0] digit1_out;
  logic [3:0] digit0_out;

  modport master (
    output row_in,
    input  col_out, key_code, key_valid, digit1_out, digit0_out
  );

  modport slave (
    input  row_in,
    output col_out, key_code, key_valid, digit1_out, digit0_out
  );
endinterface

// File: rtl/keypad_bcd_entry_scan_tick_gen.sv
// rtl/keypad_bcd_entry_scan_tick_gen.sv - one-clk scan tick each 2^SCAN_EXP cycles
module scan_tick_gen #(
  parameter int SCAN_EXP = 17
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  logic [SCAN_EXP-1:0] cnt_q;
  logic [SCAN_EXP-1:0] cnt_d;
  logic                tick_q;

  assign cnt_d = cnt_q + 1'b1;

  // Tick is registered so it lands in the cycle right after the wrap.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= &cnt_q;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/keypad_bcd_entry.sv
// rtl/keypad_bcd_entry.sv - 4x4 keypad scanner with debounce and two-digit BCD entry
module keypad_bcd_entry
  import keypad_pkg::*;
#(
  parameter int SCAN_EXP = 17,
  parameter int DB_TICKS = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic [3:0] digit1_out,
  output logic [3:0] digit0_out
);

  localparam int DBW = $clog2(DB_TICKS + 1);
  localparam logic [DBW-1:0] DB_DONE = DBW'(DB_TICKS);

  logic           tick;
  logic [3:0]     row_s1_q, row_s2_q;
  state_e         state_q, state_d;
  logic [1:0]     col_q, col_d;
  logic [DBW-1:0] db_q, db_d, db_inc;
  logic [3:0]     latch_q, latch_d;
  logic [3:0]     key_code_q, key_code_d;
  logic           key_valid_q, key_valid_d;
  logic [3:0]     dig1_q, dig1_d, dig0_q, dig0_d;

  scan_tick_gen #(.SCAN_EXP(SCAN_EXP)) u_tick (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  assign db_inc = db_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    db_d        = db_q;
    latch_d     = latch_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    dig1_d      = dig1_q;
    dig0_d      = dig0_q;

    if (tick) begin
      unique case (state_q)
        SCAN: begin
          if (is_single_key(row_s2_q)) begin
            latch_d = row_s2_q;
            db_d    = DBW'(1);
            state_d = DEBOUNCE;
          end else begin
            col_d = col_q + 2'd1;
          end
        end
        DEBOUNCE: begin
          if (row_s2_q == latch_q) begin
            if (db_inc >= DB_DONE) begin
              db_d        = '0;
              state_d     = PRESSED;
              key_valid_d = 1'b1;
              key_code_d  = KEY_MAP[{row_index(latch_q), col_q}];
            end else begin
              db_d = db_inc;
            end
          end else begin
            db_d    = '0;
            state_d = SCAN;
          end
        end
        PRESSED: begin
          if (row_s2_q == ROW_IDLE) begin
            db_d    = DBW'(1);
            state_d = RELEASE;
          end
        end
        RELEASE: begin
          // Any non-idle row during release is bounce: back to PRESSED, no new key.
          if (row_s2_q == ROW_IDLE) begin
            if (db_inc >= DB_DONE) begin
              db_d    = '0;
              state_d = SCAN;
              col_d   = col_q + 2'd1;
            end else begin
              db_d = db_inc;
            end
          end else begin
            db_d    = '0;
            state_d = PRESSED;
          end
        end
        default: state_d = SCAN;
      endcase
    end

    if (key_valid_d) begin
      if (key_code_d <= 4'd9) begin
        dig1_d = dig0_q;
        dig0_d = key_code_d;
      end else if (key_code_d == KEY_CLEAR) begin
        dig1_d = 4'd0;
        dig0_d = 4'd0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      row_s1_q    <= ROW_IDLE;
      row_s2_q    <= ROW_IDLE;
      state_q     <= SCAN;
      col_q       <= 2'd0;
      db_q        <= '0;
      latch_q     <= ROW_IDLE;
      key_code_q  <= 4'd0;
      key_valid_q <= 1'b0;
      dig1_q      <= 4'd0;
      dig0_q      <= 4'd0;
    end else begin
      row_s1_q    <= row_in;
      row_s2_q    <= row_s1_q;
      state_q     <= state_d;
      col_q       <= col_d;
      db_q        <= db_d;
      latch_q     <= latch_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      dig1_q      <= dig1_d;
      dig0_q      <= dig0_d;
    end
  end

  assign col_out    = ~(4'b0001 << col_q);
  assign key_code   = key_code_q;
  assign key_valid  = key_valid_q;
  assign digit1_out = dig1_q;
  assign digit0_out = dig0_q;

endmodule

// File: tb/tb_keypad_bcd_entry.sv
// tb/tb_keypad_bcd_entry.sv - self-checking bench for keypad_bcd_entry
module tb_keypad_bcd_entry;

  logic clk = 1'b0;
  logic reset = 1'b0;

  keypad_bcd_entry_if ifc ();

  keypad_bcd_entry #(.SCAN_EXP(2), .DB_TICKS(3)) dut (
    .clk        (clk),
    .reset      (reset),
    .row_in     (ifc.row_in),
    .col_out    (ifc.col_out),
    .key_code   (ifc.key_code),
    .key_valid  (ifc.key_valid),
    .digit1_out (ifc.digit1_out),
    .digit0_out (ifc.digit0_out)
  );

  always #5 clk = ~clk;

  // Keypad model: a held key pulls its row low only while its column is driven.
  logic       raw_en   = 1'b0;
  logic [3:0] raw_row  = 4'hF;
  logic       key_down = 1'b0;
  logic [1:0] key_r    = 2'd0;
  logic [1:0] key_c    = 2'd0;

  assign ifc.row_in = raw_en ? raw_row :
                      (key_down && ifc.col_out == ~(4'b0001 << key_c)) ? ~(4'b0001 << key_r) : 4'hF;

  int   kv_hi   = 0;
  int   kv_rise = 0;
  logic kv_prev = 1'b0;

  always @(negedge clk) begin
    if (ifc.key_valid) begin
      kv_hi++;
      if (!kv_prev) kv_rise++;
    end
    kv_prev = ifc.key_valid;
  end

  int passed = 0;
  int total  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic count_col_changes(input int n, output int ch);
    logic [3:0] prev;
    ch = 0;
    prev = ifc.col_out;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (ifc.col_out !== prev) ch++;
      prev = ifc.col_out;
    end
  endtask

  task automatic press_release(input logic [1:0] r, input logic [1:0] c);
    raw_en   = 1'b0;
    key_r    = r;
    key_c    = c;
    key_down = 1'b1;
    wait_clks(40);
    key_down = 1'b0;
    wait_clks(40);
  endtask

  typedef struct {
    logic [1:0] r;
    logic [1:0] c;
    logic [3:0] code;
    logic [3:0] d1;
    logic [3:0] d0;
  } vec_t;

  vec_t vecs [10];

  initial begin
    int errs, ch, r0, h0, lat;
    logic seen;
    logic [3:0] expc;

    vecs[0] = '{2'd1, 2'd2, 4'h6, 4'h0, 4'h6};
    vecs[1] = '{2'd1, 2'd0, 4'h4, 4'h6, 4'h4};
    vecs[2] = '{2'd0, 2'd1, 4'h2, 4'h4, 4'h2};
    vecs[3] = '{2'd0, 2'd3, 4'hA, 4'h0, 4'h0};
    vecs[4] = '{2'd3, 2'd1, 4'h0, 4'h0, 4'h0};
    vecs[5] = '{2'd2, 2'd2, 4'h9, 4'h0, 4'h9};
    vecs[6] = '{2'd3, 2'd0, 4'hE, 4'h0, 4'h9};
    vecs[7] = '{2'd2, 2'd3, 4'hC, 4'h0, 4'h9};
    vecs[8] = '{2'd3, 2'd2, 4'hF, 4'h0, 4'h9};
    vecs[9] = '{2'd0, 2'd0, 4'h1, 4'h9, 4'h1};

    wait_clks(3);
    check("rst_col", 32'(ifc.col_out), 32'hE);
    check("rst_code", 32'(ifc.key_code), 32'h0);
    check("rst_kv", 32'(ifc.key_valid), 32'h0);
    check("rst_d1", 32'(ifc.digit1_out), 32'h0);
    check("rst_d0", 32'(ifc.digit0_out), 32'h0);

    // Idle scan: column index advances once per 4 clk, first step on the 5th edge.
    reset = 1'b1;
    errs = 0;
    for (int k = 1; k <= 64; k++) begin
      @(negedge clk);
      expc = ~(4'b0001 << (((k - 1) / 4) % 4));
      if (ifc.col_out !== expc) errs++;
    end
    check("idle_col_seq_errs", 32'(errs), 32'd0);
    check("idle_no_kv", 32'(kv_hi), 32'd0);

    for (int i = 0; i < 10; i++) begin
      r0 = kv_rise;
      h0 = kv_hi;
      press_release(vecs[i].r, vecs[i].c);
      check($sformatf("v%0d_pulses", i), 32'(kv_rise - r0), 32'd1);
      check($sformatf("v%0d_width", i), 32'(kv_hi - h0), 32'd1);
      check($sformatf("v%0d_code", i), 32'(ifc.key_code), 32'(vecs[i].code));
      check($sformatf("v%0d_d1", i), 32'(ifc.digit1_out), 32'(vecs[i].d1));
      check($sformatf("v%0d_d0", i), 32'(ifc.digit0_out), 32'(vecs[i].d0));
    end

    // One-tick and two-tick glitches stay short of the debounce count.
    raw_en = 1'b1;
    raw_row = 4'hF;
    wait_clks(8);
    r0 = kv_rise;
    raw_row = 4'b1110;
    wait_clks(4);
    raw_row = 4'hF;
    count_col_changes(40, ch);
    check("glitch1_no_kv", 32'(kv_rise - r0), 32'd0);
    check("glitch1_scan_resumes", 32'(ch >= 8), 32'd1);
    raw_row = 4'b1110;
    wait_clks(8);
    raw_row = 4'hF;
    wait_clks(40);
    check("glitch2_no_kv", 32'(kv_rise - r0), 32'd0);

    // Two rows low is not a key: scanning never stops.
    raw_row = 4'b1100;
    count_col_changes(40, ch);
    check("multirow_no_kv", 32'(kv_rise - r0), 32'd0);
    check("multirow_col_steps", 32'(ch), 32'd10);
    raw_row = 4'hF;
    wait_clks(8);

    // Release bounce: idle one tick, key one tick, then idle.
    raw_en = 1'b0;
    r0 = kv_rise;
    key_r = 2'd1;
    key_c = 2'd2;
    key_down = 1'b1;
    wait_clks(40);
    check("bounce_first_kv", 32'(kv_rise - r0), 32'd1);
    key_down = 1'b0;
    wait_clks(4);
    key_down = 1'b1;
    wait_clks(4);
    key_down = 1'b0;
    wait_clks(40);
    check("bounce_no_second_kv", 32'(kv_rise - r0), 32'd1);
    check("bounce_code", 32'(ifc.key_code), 32'h6);

    // Reset while PRESSED, key kept held throughout.
    key_down = 1'b1;
    wait_clks(40);
    wait_clks(8);
    r0 = kv_rise;
    reset = 1'b0;
    wait_clks(2);
    check("midrst_col", 32'(ifc.col_out), 32'hE);
    check("midrst_code", 32'(ifc.key_code), 32'h0);
    check("midrst_kv", 32'(ifc.key_valid), 32'h0);
    check("midrst_d1", 32'(ifc.digit1_out), 32'h0);
    check("midrst_d0", 32'(ifc.digit0_out), 32'h0);
    reset = 1'b1;
    lat = 0;
    seen = 1'b0;
    while (lat < 60 && !seen) begin
      @(negedge clk);
      lat++;
      if (ifc.key_valid) seen = 1'b1;
    end
    check("midrst_kv_seen", 32'(seen), 32'd1);
    check("midrst_latency", 32'(lat), 32'd21);
    wait_clks(20);
    check("midrst_one_kv", 32'(kv_rise - r0), 32'd1);
    check("midrst_code_after", 32'(ifc.key_code), 32'h6);
    check("midrst_d1_after", 32'(ifc.digit1_out), 32'h0);
    check("midrst_d0_after", 32'(ifc.digit0_out), 32'h6);
    key_down = 1'b0;
    wait_clks(40);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
